seg7_scan_ctrl: RTL and testbench

//  Time-multiplexing scheduler for a shared seven-segment drive bus. Holds NUM_DIGITS
//  4-bit digit values plus decimal points, loaded over a valid/ready write port.

---
 rtl/seg7_pkg.sv | 14 +
 rtl/seg7.sv | 33 +++
 rtl/seg7_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// State encoding, blank pattern and digit width used by the top and decoder.
package seg7_pkg;

    typedef enum logic [1:0] {
        PARK,
        BLANK,
        SHOW
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'b0;
    localparam int         DIGIT_W   = 4;

endpackage

// File: rtl/seg7.sv
// Hex to seven-segment decoder, active-high, bit order {g,f,e,d,c,b,a}.
// Ports: digit_i = 4-bit value, seg_o = segment pattern.
module seg7
    import seg7_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [6:0]         seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        unique case (digit_i)
            4'h0: seg_o = 7'h3F;
            4'h1: seg_o = 7'h06;
            4'h2: seg_o = 7'h5B;
            4'h3: seg_o = 7'h4F;
            4'h4: seg_o = 7'h66;
            4'h5: seg_o = 7'h6D;
            4'h6: seg_o = 7'h7D;
            4'h7: seg_o = 7'h07;
            4'h8: seg_o = 7'h7F;
            4'h9: seg_o = 7'h6F;
            4'hA: seg_o = 7'h77;
            4'hB: seg_o = 7'h7C;
            4'hC: seg_o = 7'h39;
            4'hD: seg_o = 7'h5E;
            4'hE: seg_o = 7'h79;
            4'hF: seg_o = 7'h71;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Round-robin seven-segment scanner: blank guard then show interval per digit.
// Ports: clk/rst, enable, wr_* write port, segments/dp/digit_en drive, frame_tick.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SHOW_CYCLES  = 10000,
    parameter int BLANK_CYCLES = 16,
    localparam int AW = $clog2(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DIGIT_W-1:0]    wr_data,
    input  logic                  wr_dp,
    output logic                  wr_err,
    output logic [6:0]            segments,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic                  frame_tick
);

    localparam int MAXC = (SHOW_CYCLES > BLANK_CYCLES) ?
                          SHOW_CYCLES : BLANK_CYCLES;
    localparam int CW = $clog2(MAXC);
    localparam logic [CW-1:0] SHOW_LD  = CW'(SHOW_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LD = CW'(BLANK_CYCLES - 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_DIGITS - 1);
    localparam logic [AW:0]   NUM_W    = (AW + 1)'(NUM_DIGITS);

    logic [DIGIT_W-1:0]    dig_q [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] dpr_q;

    state_e                state_q;
    logic [CW-1:0]         cnt_q;
    logic [AW-1:0]         idx_q;
    logic [6:0]            seg_q;
    logic                  dp_q;
    logic [NUM_DIGITS-1:0] en_q;
    logic                  tick_q;
    logic                  ready_q;
    logic                  err_q;

    logic                  wr_fire;
    logic                  addr_ok;
    logic [6:0]            dec_seg;

    assign wr_fire = wr_valid & ready_q;
    assign addr_ok = ({1'b0, wr_addr} < NUM_W);

    // Digit storage; an out-of-range address leaves every register alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                dig_q[i] <= '0;
            end
            dpr_q <= '0;
        end else if (wr_fire && addr_ok) begin
            dig_q[wr_addr] <= wr_data;
            dpr_q[wr_addr] <= wr_dp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            err_q   <= wr_fire & ~addr_ok;
        end
    end

    // Decodes the digit about to be latched; the result is captured on
    // BLANK->SHOW entry and held, so mid-slot writes cannot glitch the display.
    seg7 u_seg7 (
        .digit_i (dig_q[idx_q]),
        .seg_o   (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PARK;
            cnt_q   <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b0;
            en_q    <= '0;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            unique case (state_q)
                PARK: begin
                    if (enable) begin
                        state_q <= BLANK;
                        cnt_q   <= BLANK_LD;
                    end
                end
                BLANK: begin
                    if (cnt_q == '0) begin
                        state_q <= SHOW;
                        cnt_q   <= SHOW_LD;
                        seg_q   <= dec_seg;
                        dp_q    <= dpr_q[idx_q];
                        en_q    <= NUM_DIGITS'(1) << idx_q;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                SHOW: begin
                    if (cnt_q == '0) begin
                        tick_q  <= (idx_q == LAST_IDX);
                        idx_q   <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                        state_q <= enable ? BLANK : PARK;
                        cnt_q   <= enable ? BLANK_LD : '0;
                        seg_q   <= SEG_BLANK;
                        dp_q    <= 1'b0;
                        en_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= PARK;
                end
            endcase
        end
    end

    assign wr_ready   = ready_q;
    assign wr_err     = err_q;
    assign segments   = seg_q;
    assign dp         = dp_q;
    assign digit_en   = en_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl against a slot-position model.
// Second small instance exercises out-of-range writes.
module tb_seg7_scan_ctrl;

    localparam int N = 4;
    localparam int S = 8;
    localparam int B = 2;

    logic       clk = 1'b0;
    logic       rst, enable, wr_valid, wr_dp;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_ready, wr_err, dp, frame_tick;
    logic [6:0] segments;
    logic [3:0] digit_en;

    logic       rst3, en3, wv3, wdp3;
    logic [1:0] wa3;
    logic [3:0] wd3;
    logic       wr_ready3, wr_err3, dp3, tick3;
    logic [6:0] seg3;
    logic [2:0] den3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .NUM_DIGITS(N), .SHOW_CYCLES(S), .BLANK_CYCLES(B)
    ) u_dut (
        .clk(clk), .rst(rst), .enable(enable),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_dp(wr_dp),
        .wr_err(wr_err), .segments(segments), .dp(dp),
        .digit_en(digit_en), .frame_tick(frame_tick)
    );

    seg7_scan_ctrl #(
        .NUM_DIGITS(3), .SHOW_CYCLES(2), .BLANK_CYCLES(1)
    ) u_dut3 (
        .clk(clk), .rst(rst3), .enable(en3),
        .wr_valid(wv3), .wr_ready(wr_ready3),
        .wr_addr(wa3), .wr_data(wd3), .wr_dp(wdp3),
        .wr_err(wr_err3), .segments(seg3), .dp(dp3),
        .digit_en(den3), .frame_tick(tick3)
    );

    function automatic logic [6:0] ref_seg(input int v);
        logic [6:0] t [16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[v & 15];
    endfunction

    // Model: a slot is B blank cycles (pos 0..B-1) then S lit cycles.
    int m_regs [N];
    bit m_dps  [N];
    bit m_ready, m_run, m_err, m_tick, m_latdp;
    int m_pos, m_idx, m_lat;

    task automatic model_edge();
        if (rst) begin
            foreach (m_regs[i]) begin
                m_regs[i] = 0;
                m_dps[i]  = 0;
            end
            m_ready = 0; m_run = 0; m_err = 0; m_tick = 0;
            m_pos = 0; m_idx = 0; m_lat = 0; m_latdp = 0;
        end else begin
            m_tick = 0;
            if (!m_run) begin
                if (enable) begin
                    m_run = 1;
                    m_pos = 0;
                end
            end else begin
                m_pos++;
                if (m_pos == B) begin
                    m_lat   = m_regs[m_idx];
                    m_latdp = m_dps[m_idx];
                end else if (m_pos == B + S) begin
                    m_tick = (m_idx == N - 1);
                    m_idx  = (m_idx + 1) % N;
                    m_pos  = 0;
                    m_run  = enable;
                end
            end
            m_err = m_ready && wr_valid && (int'(wr_addr) >= N);
            if (m_ready && wr_valid && int'(wr_addr) < N) begin
                m_regs[wr_addr] = int'(wr_data);
                m_dps[wr_addr]  = wr_dp;
            end
            m_ready = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit lit();
        return m_run && (m_pos >= B);
    endfunction

    task automatic check_all();
        bit l;
        l = lit();
        chk("digit_en", 16'(digit_en), l ? 16'(1 << m_idx) : 16'd0);
        chk("segments", 16'(segments), l ? 16'(ref_seg(m_lat)) : 16'd0);
        chk("dp", 16'(dp), l ? 16'(m_latdp) : 16'd0);
        chk("frame_tick", 16'(frame_tick), 16'(m_tick));
        chk("wr_ready", 16'(wr_ready), 16'(m_ready));
        chk("wr_err", 16'(wr_err), 16'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int g;
        rst = 1; enable = 0; wr_valid = 0; wr_addr = 0;
        wr_data = 0; wr_dp = 0;
        rst3 = 1; en3 = 0; wv3 = 0; wa3 = 0; wd3 = 0; wdp3 = 0;

        // Reset and first post-reset cycle
        tick(); tick();
        rst = 0;
        tick();
        tick();

        // Load 1,2,3,4 (dp on addr 2)
        for (int a = 0; a < N; a++) begin
            wr_valid = 1; wr_addr = 2'(a);
            wr_data = 4'(a + 1); wr_dp = (a == 2);
            tick();
        end
        wr_valid = 0; wr_dp = 0;

        // Two full frames
        enable = 1;
        for (int c = 0; c < 2 * N * (B + S); c++) tick();

        // Write digit 1 while it is lit
        for (g = 0; g < 100 && !(lit() && m_idx == 1); g++) tick();
        chk("reach_idx1", 16'(digit_en), 16'b0010);
        wr_valid = 1; wr_addr = 1; wr_data = 9;
        tick();
        wr_valid = 0;
        chk("hold_old", 16'(segments), 16'(ref_seg(2)));
        for (g = 0; g < 100 && m_idx == 1; g++) tick();
        for (g = 0; g < 100 && !(lit() && m_idx == 1); g++) tick();
        chk("new_val", 16'(segments), 16'(ref_seg(9)));

        // Drop enable on the 3rd lit cycle of idx 2
        for (g = 0; g < 200 && !(lit() && m_idx == 2 && m_pos == B + 2); g++)
            tick();
        chk("reach_idx2", 16'(digit_en), 16'b0100);
        enable = 0;
        for (int c = 0; c < 20; c++) tick();
        chk("parked", 16'(digit_en), 16'd0);
        enable = 1;
        g = 0;
        do begin
            tick();
            g++;
        end while (g < 20 && digit_en == 0);
        chk("resume_idx", 16'(digit_en), 16'b1000);
        chk("resume_lat", 16'(g), 16'(B + 1));

        // Reset in the middle of a lit slot
        for (g = 0; g < 200 && !(lit() && m_pos == B + 3); g++) tick();
        rst = 1;
        tick();
        chk("rst_en", 16'(digit_en), 16'd0);
        chk("rst_seg", 16'(segments), 16'd0);
        chk("rst_rdy", 16'(wr_ready), 16'd0);
        rst = 0;
        for (g = 0; g < 50 && !lit(); g++) tick();
        chk("rst_regs", 16'(segments), 16'(ref_seg(0)));
        for (int c = 0; c < N * (B + S); c++) tick();

        // Writes every cycle with random data for 3 frames
        for (int c = 0; c < 3 * N * (B + S); c++) begin
            wr_valid = 1;
            wr_addr  = 2'($urandom_range(0, 3));
            wr_data  = 4'($urandom_range(0, 15));
            wr_dp    = 1'($urandom_range(0, 1));
            tick();
        end
        wr_valid = 0;
        enable = 0;

        // Out-of-range write on a 3-digit instance
        rst3 = 0;
        tick();
        chk("d3_rdy", 16'(wr_ready3), 16'd1);
        for (int a = 0; a < 3; a++) begin
            wv3 = 1; wa3 = 2'(a); wd3 = 4'(5 + a);
            tick();
            chk("d3_noerr", 16'(wr_err3), 16'd0);
        end
        wa3 = 3; wd3 = 4'hF;
        tick();
        wv3 = 0;
        chk("d3_err", 16'(wr_err3), 16'd1);
        tick();
        chk("d3_err_clr", 16'(wr_err3), 16'd0);
        en3 = 1;
        for (int k = 0; k < 3; k++) begin
            for (g = 0; g < 20 && den3 !== 3'(1 << k); g++) tick();
            chk("d3_en", 16'(den3), 16'(1 << k));
            chk("d3_seg", 16'(seg3), 16'(ref_seg(5 + k)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
